// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator (h/v counters, syncs, blanking, strobes)
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CLK_DIV  = 4,
    parameter int   CNT_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             h_blank,
    output logic             v_blank,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [CNT_W-1:0] h_count, h_nxt;
    logic [CNT_W-1:0] v_count, v_nxt;
    logic             h_wrap, v_wrap;
    logic             h_blank_nxt, v_blank_nxt, hs_act_nxt, vs_act_nxt;

    assign pixel_tick = en && (div_cnt == DIV_LAST);
    assign pixel_x    = h_count;
    assign pixel_y    = v_count;

    always_comb begin
        div_nxt = div_cnt;
        h_nxt   = h_count;
        v_nxt   = v_count;
        h_wrap  = 1'b0;
        v_wrap  = 1'b0;
        if (clr) begin
            div_nxt = '0;
            h_nxt   = '0;
            v_nxt   = '0;
        end else if (en) begin
            div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (pixel_tick) begin
                if (h_count == H_LAST) begin
                    h_nxt  = '0;
                    h_wrap = 1'b1;
                    if (v_count == V_LAST) begin
                        v_nxt  = '0;
                        v_wrap = 1'b1;
                    end else begin
                        v_nxt = v_count + 1'b1;
                    end
                end else begin
                    h_nxt = h_count + 1'b1;
                end
            end
        end
    end

    // Decode the next-state counts so registered flags line up with pixel_x/pixel_y
    assign h_blank_nxt = (h_nxt >= H_ACT);
    assign v_blank_nxt = (v_nxt >= V_ACT);
    assign hs_act_nxt  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
    assign vs_act_nxt  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            h_count     <= '0;
            v_count     <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            video_on    <= 1'b0;
            h_blank     <= 1'b0;
            v_blank     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (clr || en) begin
            div_cnt     <= div_nxt;
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            hsync       <= hs_act_nxt ? H_POL : ~H_POL;
            vsync       <= vs_act_nxt ? V_POL : ~V_POL;
            video_on    <= !h_blank_nxt && !v_blank_nxt;
            h_blank     <= h_blank_nxt;
            v_blank     <= v_blank_nxt;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on two small raster modes
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;

    logic       tick0, hs0, vs0, von0, hb0, vb0, ls0, fs0;
    logic [3:0] px0, py0;
    logic       tick1, hs1, vs1, von1, hb1, vb1, ls1, fs1;
    logic [3:0] px1, py1;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b1), .CLK_DIV(3), .CNT_W(4)
    ) dut0 (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .pixel_tick(tick0), .pixel_x(px0), .pixel_y(py0),
        .hsync(hs0), .vsync(vs0), .video_on(von0),
        .h_blank(hb0), .v_blank(vb0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CNT_W(4)
    ) dut1 (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .pixel_tick(tick1), .pixel_x(px1), .pixel_y(py1),
        .hsync(hs1), .vsync(vs1), .video_on(von1),
        .h_blank(hb1), .v_blank(vb1),
        .line_start(ls1), .frame_start(fs1)
    );

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit hpol, vpol;
        int cdiv;
    } cfg_t;

    typedef struct {
        int div, h, v;
        bit hs, vs, von, hb, vb, ls, fs;
    } mst_t;

    cfg_t c0, c1;
    mst_t m0, m1;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int tests = 0;
    int fails = 0;

    function automatic mst_t mreset(cfg_t c);
        mst_t s;
        s.div = 0; s.h = 0; s.v = 0;
        s.hs = !c.hpol; s.vs = !c.vpol;
        s.von = 0; s.hb = 0; s.vb = 0; s.ls = 0; s.fs = 0;
        return s;
    endfunction

    function automatic mst_t mnext(mst_t s, cfg_t c, bit e, bit cl);
        mst_t n = s;
        int ht = c.ha + c.hfp + c.hs + c.hbp;
        int vt = c.va + c.vfp + c.vs + c.vbp;
        bit tick = e && (s.div == c.cdiv - 1);
        bit hw = 0;
        bit vw = 0;
        if (cl) begin
            n.div = 0; n.h = 0; n.v = 0;
        end else if (e) begin
            n.div = (s.div + 1) % c.cdiv;
            if (tick) begin
                if (s.h == ht - 1) begin
                    n.h = 0; hw = 1;
                    if (s.v == vt - 1) begin n.v = 0; vw = 1; end
                    else n.v = s.v + 1;
                end else begin
                    n.h = s.h + 1;
                end
            end
        end
        if (cl || e) begin
            n.hb  = (n.h >= c.ha);
            n.vb  = (n.v >= c.va);
            n.von = !n.hb && !n.vb;
            n.hs  = (n.h >= c.ha + c.hfp && n.h < c.ha + c.hfp + c.hs) ? c.hpol : !c.hpol;
            n.vs  = (n.v >= c.va + c.vfp && n.v < c.va + c.vfp + c.vs) ? c.vpol : !c.vpol;
            n.ls  = hw;
            n.fs  = hw && vw;
        end
        return n;
    endfunction

    function automatic logic [31:0] pack_m(mst_t s);
        return {9'd0, 8'(s.h), 8'(s.v), s.hs, s.vs, s.von, s.hb, s.vb, s.ls, s.fs};
    endfunction

    function automatic logic [31:0] obs0();
        return {9'd0, 8'(px0), 8'(py0), hs0, vs0, von0, hb0, vb0, ls0, fs0};
    endfunction

    function automatic logic [31:0] obs1();
        return {9'd0, 8'(px1), 8'(py1), hs1, vs1, von1, hb1, vb1, ls1, fs1};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, then compare both DUTs just after the edge
    task automatic step(input logic e, input logic c);
        en = e;
        clr = c;
        #1;
        check("tick0", {31'd0, tick0}, {31'd0, e && (m0.div == c0.cdiv - 1)});
        check("tick1", {31'd0, tick1}, {31'd0, e && (m1.div == c1.cdiv - 1)});
        m0 = mnext(m0, c0, e, c);
        m1 = mnext(m1, c1, e, c);
        q0.push_back(pack_m(m0));
        q1.push_back(pack_m(m1));
        @(posedge clk);
        #1;
        check("dut0", obs0(), q0.pop_front());
        check("dut1", obs1(), q1.pop_front());
    endtask

    function automatic bit sig(input int which);
        case (which)
            0: return ls0;
            1: return fs0;
            2: return ls1;
            3: return fs1;
            4: return (px0 == 4'd5);
            5: return (px0 == 4'd11) && (py0 == 4'd2);
            6: return (px0 == 4'd6) && (py0 == 4'd3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_until(input int which, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            step(1'b1, 1'b0);
            cyc++;
        end while (!sig(which) && cyc < max_cyc);
    endtask

    initial begin
        int cyc;
        int cnt;
        logic [31:0] snap0, snap1;

        c0 = '{ha:8, hfp:2, hs:2, hbp:2, va:4, vfp:1, vs:1, vbp:1, hpol:1'b0, vpol:1'b1, cdiv:3};
        c1 = '{ha:8, hfp:2, hs:2, hbp:2, va:4, vfp:1, vs:1, vbp:1, hpol:1'b1, vpol:1'b1, cdiv:1};
        m0 = mreset(c0);
        m1 = mreset(c1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_state0", obs0(), {9'd0, 8'd0, 8'd0, 7'b1000000});
        check("rst_state1", obs1(), {9'd0, 8'd0, 8'd0, 7'b0000000});
        reset = 1'b1;

        step(1'b1, 1'b0);
        check("first_video_on", {31'd0, von0}, 32'd1);
        check("first_no_strobe", {30'd0, ls0, fs0}, 32'd0);

        run_until(2, 200, cyc);
        run_until(2, 200, cyc);
        check("line_period1", cyc, 32'd14);
        run_until(3, 400, cyc);
        run_until(3, 400, cyc);
        check("frame_period1", cyc, 32'd98);
        check("frame_has_line1", {31'd0, ls1}, 32'd1);

        cnt = 0;
        for (int i = 0; i < 98; i++) begin
            step(1'b1, 1'b0);
            if (vs1) cnt++;
        end
        check("vsync_clks1", cnt, 32'd14);
        cnt = 0;
        for (int i = 0; i < 98; i++) begin
            step(1'b1, 1'b0);
            if (von1) cnt++;
        end
        check("video_clks1", cnt, 32'd32);

        run_until(0, 200, cyc);
        run_until(0, 200, cyc);
        check("line_period0", cyc, 32'd42);
        cnt = 0;
        for (int i = 0; i < 42; i++) begin
            step(1'b1, 1'b0);
            if (!hs0) cnt++;
        end
        check("hsync_clks0", cnt, 32'd6);
        run_until(1, 400, cyc);
        run_until(1, 400, cyc);
        check("frame_period0", cyc, 32'd294);

        // Freeze mid-line at a non-zero divider phase
        run_until(4, 400, cyc);
        check("locate_freeze", {31'd0, sig(4)}, 32'd1);
        step(1'b1, 1'b0);
        snap0 = obs0();
        snap1 = obs1();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        check("freeze0", obs0(), snap0);
        check("freeze1", obs1(), snap1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

        run_until(5, 400, cyc);
        check("locate_clr", {31'd0, sig(5)}, 32'd1);
        step(1'b1, 1'b1);
        check("clr_pos", {24'd0, px0, py0}, 32'd0);
        check("clr_flags", {29'd0, von0, ls0, fs0}, 32'b100);
        run_until(0, 200, cyc);
        check("clr_line_period", cyc, 32'd42);

        // Asynchronous reset mid-frame, released away from the clock edge
        run_until(6, 400, cyc);
        check("locate_rst", {31'd0, sig(6)}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst0", obs0(), {9'd0, 8'd0, 8'd0, 7'b1000000});
        check("async_rst1", obs1(), {9'd0, 8'd0, 8'd0, 7'b0000000});
        m0 = mreset(c0);
        m1 = mreset(c1);
        #1;
        reset = 1'b1;
        run_until(1, 400, cyc);
        check("rst_frame_period0", cyc, 32'd294);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync block; generates horizontal/vertical timing for any raster mode.
- All porch, sync and active lengths, sync polarities and the pixel-clock divide ratio are parameters.
- Adds pixel-rate enable, synchronous restart, separate blanking flags and line/frame start strobes.
- Feeds the pixel pipeline and the VGA connector; pixel_x/pixel_y address the frame buffer.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
CLK_DIV, 4, clk cycles per pixel, >=1
CNT_W, 11, counter width; must satisfy 2^CNT_W >= H_TOTAL and 2^CNT_W >= V_TOTAL

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  run enable; 0 freezes all state
clr  in  1  synchronous restart to pixel (0,0)
pixel_tick  out  1  pixel-rate strobe (combinational)
pixel_x  out  CNT_W  current h_count
pixel_y  out  CNT_W  current v_count
hsync  out  1  horizontal sync, polarity per H_POL
vsync  out  1  vertical sync, polarity per V_POL
video_on  out  1  high in active region
h_blank  out  1  high when h_count >= H_ACTIVE
v_blank  out  1  high when v_count >= V_ACTIVE
line_start  out  1  one-clk pulse on first clk of each new line
frame_start  out  1  one-clk pulse on first clk of each new frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 800 x 525.
- Divider div_cnt counts 0..CLK_DIV-1, advancing only when en=1.
- pixel_tick = en && (div_cnt == CLK_DIV-1). With CLK_DIV=1, pixel_tick = en.
- On pixel_tick:
  - h_count wraps H_TOTAL-1 -> 0, otherwise increments.
  - v_count advances only on that h wrap; it wraps V_TOTAL-1 -> 0, otherwise increments.
- clr=1 takes priority over en and tick: next clk div_cnt=h_count=v_count=0. No line_start or frame_start is generated by clr.
- en=0 and clr=0: counters, divider and all registered outputs hold their values.
- Output registers (hsync, vsync, video_on, h_blank, v_blank, line_start, frame_start) load the decode of next-state counts each enabled clk. They are therefore always aligned with pixel_x/pixel_y; no extra latency.
- hsync is at active level iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (defaults: 656..751).
- vsync is at active level iff V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (defaults: 490..491).
- video_on = !h_blank && !v_blank.
- line_start = 1 for exactly one clk when h_count has just wrapped to 0 by a tick.
- frame_start = 1 for exactly one clk when (h,v) has just wrapped to (0,0) by a tick. frame_start implies line_start.
- Reset (async assert, any time including mid-frame):
  - counters = 0, div_cnt = 0.
  - hsync = !H_POL, vsync = !V_POL.
  - video_on, h_blank, v_blank, line_start, frame_start = 0.
  - From the first clk edge after reset release (en=1 or clr=1), outputs reflect (0,0): video_on=1, blanks 0.
  - No strobe is emitted for the post-reset (0,0).
- Arithmetic is unsigned CNT_W. Counters never exceed TOTAL-1.

Test Plan:
- Defaults, en=1 after reset: hsync falls when pixel_x=656, stays low 384 clks, rises at pixel_x=752; line_start period 3200 clks; frame_start period 1,680,000 clks.
- Defaults: vsync low exactly for pixel_y 490..491 (6400 clks); video_on=0 for all pixel_x>=640 or pixel_y>=480; h_blank/v_blank match.
- CLK_DIV=1, H=8/2/2/2, V=4/1/1/1, H_POL=V_POL=1: hsync high for pixel_x 10..11 every 14 clks; frame_start every 98 clks coincident with line_start.
- en low for 50 clks mid-line at pixel_x=300: pixel_x, div_cnt and all outputs frozen; counting resumes at the exact divider phase.
- clr pulsed at (700,100): next clk pixel_x=pixel_y=0, video_on=1, no line_start/frame_start; next line_start 3200 clks later.
- reset asserted at (500,300) asynchronously: outputs immediately go to reset values; after release, the sequence restarts from (0,0) and the first frame_start appears 1,680,000 clks later.
